branch_ctrl: RTL and testbench
==============================

# branch_ctrl

Branch resolution stage directly upstream of the program counter. It accepts branch requests from the decoder and resolves conditional branches against the ALU zero flag one cycle later. It then drives the PC's `branch_en` and 12-bit `target` for exactly one cycle per taken branch. Absolute targets come from a 16-entry writable target LUT; relative targets are PC + signed 8-bit offset.

## Interface
- No parameters. Widths are fixed: PC 12 bits, LUT 16 x 12, offset 8.
- `CLK`  in  1  sole clock; all state updates on the rising edge.
- `init_n`  in  1  asynchronous, active-low reset.
- `br_req`  in  1  decoder branch request; one-cycle pulse.
- `br_kind`  in  2  branch kind: 00 = always, LUT target; 01 = if zero, LUT target; 10 = if not zero, LUT target; 11 = always, relative.
- `lut_idx`  in  4  LUT index for kinds 00/01/10.
- `rel_off`  in  8  signed offset for kind 11.
- `pc`  in  12  PC of the branch instruction, valid with `br_req`.
- `zero_flag`  in  1  ALU zero flag; valid the cycle after `br_req`.
- `halt`  in  1  halt from the PC.
- `lut_we`  in  1  LUT write enable.
- `lut_waddr`  in  4  LUT write address.
- `lut_wdata`  in  12  LUT write data.
- `branch_en`  out  1  redirect strobe to the PC.
- `target`  out  12  redirect address; meaningful only while `branch_en` is high.
- `squash`  out  1  tells fetch to discard the instruction currently in flight.
- `busy`  out  1  high while a request is in flight.
- `req_err`  out  1  sticky flag: a request was dropped.

## Operation
- States are IDLE, EVAL and REDIRECT. The encoding is free, but unused encodings must return to IDLE.
- **IDLE:** if `br_req && !halt`, capture `br_kind`, `lut_idx`, `rel_off` and `pc`, then go to EVAL. Otherwise stay.
- **EVAL:** compute taken.
  - Kinds 00 and 11 are always taken.
  - Kind 01 is taken when `zero_flag` = 1; kind 10 when `zero_flag` = 0. `zero_flag` is sampled in this cycle only.
  - Taken: register `target`, go to REDIRECT.
  - Not taken: go to IDLE with no output strobe.
- **Target computation:**
  - LUT kinds: `target` = LUT[captured idx], read in EVAL.
  - Kind 11: `target` = captured `pc` + sign-extended `rel_off`, truncated to 12 bits, so the result wraps modulo 4096.
  - Examples: pc 0xFFE + 5 = 0x003; pc 0x002 + (-4) = 0xFFE.
- **REDIRECT:** `branch_en` = 1 and `squash` = 1 for exactly one cycle, then return to IDLE.
- **`busy`:** 1 in EVAL and REDIRECT.
- **Request while busy:** the request is ignored, the in-flight branch is unaffected, and `req_err` is set. `req_err` clears only on reset.
- **Request while halted:** `br_req` with `halt` = 1 in IDLE is ignored silently; `req_err` is not set.
- **`halt` rising while in flight:** the in-flight branch still completes.
- **LUT writes:**
  - Accepted in any state.
  - A write to the index being read in the same EVAL cycle returns the old value (read-before-write).
  - The new value is visible from the next cycle.
- **Reset:** `init_n` low at any time, including mid-operation, immediately forces:
  - state to IDLE;
  - `branch_en`, `squash`, `busy`, `req_err` and `target` to 0;
  - all LUT entries to 0.
  - A branch interrupted by reset is lost, with no strobe.

## Timing
- Cycle N: `br_req` is sampled.
- Cycle N+1: EVAL, `zero_flag` is sampled, `busy` = 1.
- Cycle N+2: `branch_en` = 1 and `target` is valid; the PC loads `target` at the end of N+2.
- Taken-branch latency is 2 cycles from request to strobe. Not-taken is 1 cycle; `busy` drops at N+2.
- Earliest next accepted request: N+3 when taken, N+2 when not taken.
- All outputs are registered; none is combinational from inputs.
- Reset deassertion: the first active edge is the one after `init_n` rises.

## Configuration
- Macro: `BRANCH_CTRL_STATS_EN`.
- **Defined:** adds output `taken_cnt[15:0]` and output `resolved_cnt[15:0]`.
  - `taken_cnt` increments on each REDIRECT cycle.
  - `resolved_cnt` increments on each EVAL cycle.
  - Both saturate at 0xFFFF and both reset to 0.
- **Undefined:** neither port nor counter exists. All other behaviour is identical.

## Test plan
- **LUT absolute:** reset, write LUT[3] = 0x2A0, request kind 00, idx 3, pc 0x010 at cycle N → `branch_en` = 1 and `target` = 0x2A0 at N+2 only; `busy` high N+1..N+2.
- **Conditional:**
  - Kind 01 with `zero_flag` = 0 at N+1 → no `branch_en`; `busy` low at N+2.
  - Kind 10 with `zero_flag` = 0 → taken, `target` = LUT value.
- **Relative wrap:**
  - Kind 11, pc 0xFFE, off 0x05 → `target` 0x003.
  - Kind 11, pc 0x002, off 0xFC → `target` 0xFFE.
- **Collision:**
  - Request at N and again at N+1 → only the first resolves; `req_err` = 1 and stays high.
  - LUT write to idx 3 with new value 0x111 during EVAL → `target` = old value 0x2A0.
- **Reset mid-operation:** assert `init_n` = 0 during EVAL → `busy` = 0 immediately, no `branch_en`, LUT[3] reads 0 afterwards.
- **Halt and stats:**
  - `halt` = 1 with `br_req` in IDLE → ignored, `req_err` = 0.
  - With `BRANCH_CTRL_STATS_EN` defined: 3 taken plus 2 not-taken branches → `taken_cnt` = 3, `resolved_cnt` = 5.

Source files
------------

// File: rtl/branch_ctrl.sv
// branch_ctrl: branch resolution stage feeding the program counter.
// Captures a decoder branch request, resolves it against the ALU zero flag
// one cycle later, and strobes branch_en/squash with a 12-bit target for a
// single cycle per taken branch. Absolute targets come from a 16 x 12
// writable LUT; relative targets are pc + signed 8-bit offset (mod 4096).
// Optional build macro BRANCH_CTRL_STATS_EN adds saturating taken/resolved
// event counters (taken_cnt, resolved_cnt).
module branch_ctrl (
  input  logic        CLK,
  input  logic        init_n,
  input  logic        br_req,
  input  logic [1:0]  br_kind,
  input  logic [3:0]  lut_idx,
  input  logic [7:0]  rel_off,
  input  logic [11:0] pc,
  input  logic        zero_flag,
  input  logic        halt,
  input  logic        lut_we,
  input  logic [3:0]  lut_waddr,
  input  logic [11:0] lut_wdata,
  output logic        branch_en,
  output logic [11:0] target,
  output logic        squash,
  output logic        busy,
  output logic        req_err
`ifdef BRANCH_CTRL_STATS_EN
  ,
  output logic [15:0] taken_cnt,
  output logic [15:0] resolved_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    EVAL     = 2'b01,
    REDIRECT = 2'b10
  } state_t;

  localparam logic [1:0] KIND_ALWAYS  = 2'b00;
  localparam logic [1:0] KIND_IF_Z    = 2'b01;
  localparam logic [1:0] KIND_IF_NZ   = 2'b10;
  localparam logic [1:0] KIND_REL     = 2'b11;

  state_t state, state_nxt;

  // Request fields captured on acceptance; pure data, so no reset.
  logic [1:0]         kind_p0;
  logic [3:0]         idx_p0;
  logic signed [7:0]  off_p0;
  logic [11:0]        pc_p0;

  logic [11:0]        lut [16];
  logic               taken;
  logic               accept;
  logic [11:0]        target_nxt;

  // pc + sign-extended offset, truncated so the result wraps modulo 4096.
  function automatic logic [11:0] rel_target(input logic [11:0] base,
                                             input logic signed [7:0] off);
    logic signed [11:0] off_ext;
    off_ext = 12'(off);
    return base + off_ext;
  endfunction

`ifdef BRANCH_CTRL_STATS_EN
  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] val);
    return (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction
`endif

  assign accept = (state == IDLE) && br_req && !halt;

  // Resolve the captured branch against the zero flag sampled this cycle.
  always_comb begin
    taken = 1'b0;
    case (kind_p0)
      KIND_ALWAYS: taken = 1'b1;
      KIND_IF_Z:   taken = zero_flag;
      KIND_IF_NZ:  taken = !zero_flag;
      KIND_REL:    taken = 1'b1;
      default:     taken = 1'b0;
    endcase
  end

  // Select the redirect address: relative sum or LUT entry (old contents
  // if written this same cycle, since the LUT update is non-blocking).
  always_comb begin
    target_nxt = lut[idx_p0];
    if (kind_p0 == KIND_REL) begin
      target_nxt = rel_target(pc_p0, off_p0);
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge init_n) begin
    if (!init_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; stray encodings fall back to IDLE.
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:     state_nxt = accept ? EVAL : IDLE;
      EVAL:     state_nxt = taken ? REDIRECT : IDLE;
      REDIRECT: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Moore outputs decoded from the state register only.
  always_comb begin
    branch_en = 1'b0;
    squash    = 1'b0;
    busy      = 1'b0;
    case (state)
      EVAL: begin
        busy = 1'b1;
      end
      REDIRECT: begin
        branch_en = 1'b1;
        squash    = 1'b1;
        busy      = 1'b1;
      end
      default: begin
        branch_en = 1'b0;
        squash    = 1'b0;
        busy      = 1'b0;
      end
    endcase
  end

  // Capture the request fields when a request is accepted in IDLE.
  always_ff @(posedge CLK) begin
    if (accept) begin
      kind_p0 <= br_kind;
      idx_p0  <= lut_idx;
      off_p0  <= rel_off;
      pc_p0   <= pc;
    end
  end

  // Target register, loaded only when the branch resolves taken.
  always_ff @(posedge CLK or negedge init_n) begin
    if (!init_n) begin
      target <= 12'h000;
    end else if ((state == EVAL) && taken) begin
      target <= target_nxt;
    end
  end

  // Sticky error: any request arriving while a branch is in flight.
  always_ff @(posedge CLK or negedge init_n) begin
    if (!init_n) begin
      req_err <= 1'b0;
    end else if (br_req && ((state == EVAL) || (state == REDIRECT))) begin
      req_err <= 1'b1;
    end
  end

  // Target LUT: cleared on reset, writable in any state.
  always_ff @(posedge CLK or negedge init_n) begin
    if (!init_n) begin
      for (int i = 0; i < 16; i++) begin
        lut[i] <= 12'h000;
      end
    end else if (lut_we) begin
      lut[lut_waddr] <= lut_wdata;
    end
  end

`ifdef BRANCH_CTRL_STATS_EN
  // Saturating event counters: taken redirects and resolutions.
  always_ff @(posedge CLK or negedge init_n) begin
    if (!init_n) begin
      taken_cnt    <= 16'h0000;
      resolved_cnt <= 16'h0000;
    end else begin
      if (state == REDIRECT) begin
        taken_cnt <= sat_inc(taken_cnt);
      end
      if (state == EVAL) begin
        resolved_cnt <= sat_inc(resolved_cnt);
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed testbench for branch_ctrl with hand-computed expectations.
module tb_branch_ctrl;

  logic        CLK = 1'b0;
  logic        init_n;
  logic        br_req;
  logic [1:0]  br_kind;
  logic [3:0]  lut_idx;
  logic [7:0]  rel_off;
  logic [11:0] pc;
  logic        zero_flag;
  logic        halt;
  logic        lut_we;
  logic [3:0]  lut_waddr;
  logic [11:0] lut_wdata;
  logic        branch_en;
  logic [11:0] target;
  logic        squash;
  logic        busy;
  logic        req_err;
`ifdef BRANCH_CTRL_STATS_EN
  logic [15:0] taken_cnt;
  logic [15:0] resolved_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  branch_ctrl dut (
    .CLK       (CLK),
    .init_n    (init_n),
    .br_req    (br_req),
    .br_kind   (br_kind),
    .lut_idx   (lut_idx),
    .rel_off   (rel_off),
    .pc        (pc),
    .zero_flag (zero_flag),
    .halt      (halt),
    .lut_we    (lut_we),
    .lut_waddr (lut_waddr),
    .lut_wdata (lut_wdata),
    .branch_en (branch_en),
    .target    (target),
    .squash    (squash),
    .busy      (busy),
    .req_err   (req_err)
`ifdef BRANCH_CTRL_STATS_EN
    ,
    .taken_cnt    (taken_cnt),
    .resolved_cnt (resolved_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic lut_write(input logic [3:0] a, input logic [11:0] d);
    lut_we    = 1'b1;
    lut_waddr = a;
    lut_wdata = d;
    tick();
    lut_we    = 1'b0;
  endtask

  task automatic apply_reset();
    init_n = 1'b0;
    #12;
    init_n = 1'b1;
    tick();
  endtask

  // One branch request; zero_flag holds its real value only in EVAL, and
  // request fields are scrambled after cycle N to prove they were captured.
  task automatic do_branch(input string tag, input logic [1:0] kind,
                           input logic [3:0] idx, input logic [7:0] off,
                           input logic [11:0] p, input logic zf,
                           input logic taken, input logic [11:0] exp_tgt);
    br_req    = 1'b1;
    br_kind   = kind;
    lut_idx   = idx;
    rel_off   = off;
    pc        = p;
    zero_flag = ~zf;
    tick();
    br_req    = 1'b0;
    br_kind   = ~kind;
    lut_idx   = ~idx;
    rel_off   = ~off;
    pc        = ~p;
    zero_flag = zf;
    chk({tag, " busy@N+1"}, busy, 1'b1);
    chk({tag, " en@N+1"}, branch_en, 1'b0);
    tick();
    zero_flag = ~zf;
    if (taken) begin
      chk({tag, " en@N+2"}, branch_en, 1'b1);
      chk({tag, " squash@N+2"}, squash, 1'b1);
      chk({tag, " busy@N+2"}, busy, 1'b1);
      chk({tag, " target"}, target, exp_tgt);
    end else begin
      chk({tag, " en@N+2"}, branch_en, 1'b0);
      chk({tag, " busy@N+2"}, busy, 1'b0);
    end
    tick();
    chk({tag, " en@N+3"}, branch_en, 1'b0);
    chk({tag, " busy@N+3"}, busy, 1'b0);
  endtask

  initial begin
    init_n    = 1'b0;
    br_req    = 1'b0;
    br_kind   = 2'b00;
    lut_idx   = 4'h0;
    rel_off   = 8'h00;
    pc        = 12'h000;
    zero_flag = 1'b0;
    halt      = 1'b0;
    lut_we    = 1'b0;
    lut_waddr = 4'h0;
    lut_wdata = 12'h000;

    #3;
    chk("rst branch_en", branch_en, 1'b0);
    chk("rst squash", squash, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst req_err", req_err, 1'b0);
    chk("rst target", target, 12'h000);
`ifdef BRANCH_CTRL_STATS_EN
    chk("rst taken_cnt", taken_cnt, 16'h0000);
    chk("rst resolved_cnt", resolved_cnt, 16'h0000);
`endif
    #10;
    init_n = 1'b1;
    tick();

    lut_write(4'd3, 12'h2A0);
    lut_write(4'd5, 12'h155);

    do_branch("abs k00", 2'b00, 4'd3, 8'h00, 12'h010, 1'b0, 1'b1, 12'h2A0);
    do_branch("k01 z0", 2'b01, 4'd3, 8'h00, 12'h020, 1'b0, 1'b0, 12'h000);
    do_branch("k10 z0", 2'b10, 4'd5, 8'h00, 12'h030, 1'b0, 1'b1, 12'h155);
    do_branch("k01 z1", 2'b01, 4'd5, 8'h00, 12'h040, 1'b1, 1'b1, 12'h155);
    do_branch("k10 z1", 2'b10, 4'd3, 8'h00, 12'h050, 1'b1, 1'b0, 12'h000);
    do_branch("rel wrap+", 2'b11, 4'd0, 8'h05, 12'hFFE, 1'b0, 1'b1, 12'h003);
    do_branch("rel wrap-", 2'b11, 4'd0, 8'hFC, 12'h002, 1'b1, 1'b1, 12'hFFE);
    chk("req_err clean", req_err, 1'b0);

    // Halt with a request in IDLE: silently ignored.
    halt   = 1'b1;
    br_req = 1'b1;
    tick();
    br_req = 1'b0;
    chk("halt ignore busy", busy, 1'b0);
    tick();
    chk("halt ignore en", branch_en, 1'b0);
    chk("halt req_err", req_err, 1'b0);
    halt = 1'b0;

    // Halt rising while in flight: branch still completes.
    br_req  = 1'b1;
    br_kind = 2'b11;
    pc      = 12'h100;
    rel_off = 8'h10;
    tick();
    br_req = 1'b0;
    halt   = 1'b1;
    tick();
    chk("halt inflight en", branch_en, 1'b1);
    chk("halt inflight target", target, 12'h110);
    halt = 1'b0;
    tick();

    // LUT write to the index being read during EVAL returns the old value.
    br_req  = 1'b1;
    br_kind = 2'b00;
    lut_idx = 4'd3;
    tick();
    br_req    = 1'b0;
    lut_we    = 1'b1;
    lut_waddr = 4'd3;
    lut_wdata = 12'h111;
    tick();
    lut_we = 1'b0;
    chk("rbw en", branch_en, 1'b1);
    chk("rbw target old", target, 12'h2A0);
    tick();
    do_branch("rbw new", 2'b00, 4'd3, 8'h00, 12'h060, 1'b0, 1'b1, 12'h111);

    // Collision: second request during EVAL is dropped and flagged.
    br_req  = 1'b1;
    br_kind = 2'b00;
    lut_idx = 4'd5;
    tick();
    br_kind = 2'b11;
    pc      = 12'h200;
    rel_off = 8'h01;
    tick();
    br_req = 1'b0;
    chk("coll en", branch_en, 1'b1);
    chk("coll target", target, 12'h155);
    chk("coll req_err", req_err, 1'b1);
    tick();
    chk("coll dropped busy", busy, 1'b0);
    chk("coll dropped en", branch_en, 1'b0);
    do_branch("after coll", 2'b11, 4'd0, 8'h02, 12'h300, 1'b0, 1'b1, 12'h302);
    chk("req_err sticky", req_err, 1'b1);

    // Reset during EVAL: immediate clear, branch lost, LUT wiped.
    br_req  = 1'b1;
    br_kind = 2'b00;
    lut_idx = 4'd3;
    tick();
    br_req = 1'b0;
    chk("mid busy pre", busy, 1'b1);
    #1;
    init_n = 1'b0;
    #1;
    chk("mid busy", busy, 1'b0);
    chk("mid en", branch_en, 1'b0);
    chk("mid req_err", req_err, 1'b0);
    chk("mid target", target, 12'h000);
    #1;
    init_n = 1'b1;
    tick();
    chk("mid lost en", branch_en, 1'b0);
    chk("mid lost busy", busy, 1'b0);
    do_branch("lut cleared", 2'b00, 4'd3, 8'h00, 12'h070, 1'b0, 1'b1, 12'h000);

    // Fresh reset then 3 taken + 2 not-taken branches.
    apply_reset();
    lut_write(4'd7, 12'h777);
    do_branch("st1", 2'b00, 4'd7, 8'h00, 12'h000, 1'b0, 1'b1, 12'h777);
    do_branch("st2", 2'b01, 4'd7, 8'h00, 12'h000, 1'b0, 1'b0, 12'h000);
    do_branch("st3", 2'b11, 4'd0, 8'h80, 12'h100, 1'b0, 1'b1, 12'h080);
    do_branch("st4", 2'b10, 4'd7, 8'h00, 12'h000, 1'b1, 1'b0, 12'h000);
    do_branch("st5", 2'b10, 4'd7, 8'h00, 12'h000, 1'b0, 1'b1, 12'h777);
`ifdef BRANCH_CTRL_STATS_EN
    chk("taken_cnt", taken_cnt, 16'd3);
    chk("resolved_cnt", resolved_cnt, 16'd5);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
